// File: rtl/vfxp_round_wb.sv
// Writeback stage behind the vector add/min/max unit: applies vxrm rounding
// increments to averaging results, then buffers beats in a small FIFO that
// feeds the register-file write port under valid/ready backpressure.
module vfxp_round_wb #(
   parameter int DATA_WIDTH    = 64,
   parameter int BE_WIDTH      = DATA_WIDTH / 8,
   parameter int ADDR_WIDTH    = 32,
   parameter int DEPTH         = 4,
   parameter bit ENABLE_64_BIT = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_vec,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [BE_WIDTH-1:0]   in_be,
   input  logic                  in_mask,
   input  logic                  in_fxp,
   input  logic [BE_WIDTH-1:0]   in_vd,
   input  logic [BE_WIDTH-1:0]   in_vd1,
   input  logic [1:0]            in_sew,
   input  logic [1:0]            in_vxrm,
   output logic                  in_almost_full,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_vec,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [BE_WIDTH-1:0]   out_be,
   output logic                  out_mask,
   output logic                  overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Rounding increment for one element from its v[d] / v[d-1] bits.
   function automatic logic f_rbit(input logic vd, input logic vd1, input logic [1:0] vxrm);
      case (vxrm)
         2'd0:    return vd1;          // rnu
         2'd1:    return vd1 & vd;     // rne
         2'd2:    return 1'b0;         // rdn
         default: return ~vd & vd1;    // rod
      endcase
   endfunction

   logic                  w_round_en;
   logic [DATA_WIDTH-1:0] w_rnd_vec;

   // Stage R registers
   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_vec;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [BE_WIDTH-1:0]   r_be;
   logic                  r_mask;

   // FIFO storage and control
   logic [DATA_WIDTH-1:0] r_mem_vec  [DEPTH];
   logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
   logic [BE_WIDTH-1:0]   r_mem_be   [DEPTH];
   logic                  r_mem_mask [DEPTH];
   logic [PW-1:0]         r_wptr;
   logic [PW-1:0]         r_rptr;
   logic [CW-1:0]         r_count;
   logic                  r_overflow;

   logic w_full;
   logic w_push;
   logic w_pop;
   logic w_accept;

   assign w_round_en = in_fxp & ~in_mask & ((in_sew != 2'b11) | ENABLE_64_BIT);

   // Per-element rounding; each element adds its own increment so carries
   // stay inside the element.
   always_comb begin
      w_rnd_vec = in_vec;
      if (w_round_en) begin
         case (in_sew)
            2'd0: begin
               for (int unsigned i = 0; i < BE_WIDTH; i++)
                  w_rnd_vec[8*i +: 8] = in_vec[8*i +: 8]
                     + {7'd0, f_rbit(in_vd[i], in_vd1[i], in_vxrm)};
            end
            2'd1: begin
               for (int unsigned i = 0; i < BE_WIDTH/2; i++)
                  w_rnd_vec[16*i +: 16] = in_vec[16*i +: 16]
                     + {15'd0, f_rbit(in_vd[2*i], in_vd1[2*i], in_vxrm)};
            end
            2'd2: begin
               for (int unsigned i = 0; i < BE_WIDTH/4; i++)
                  w_rnd_vec[32*i +: 32] = in_vec[32*i +: 32]
                     + {31'd0, f_rbit(in_vd[4*i], in_vd1[4*i], in_vxrm)};
            end
            default: begin
               for (int unsigned i = 0; i < BE_WIDTH/8; i++)
                  w_rnd_vec[64*i +: 64] = in_vec[64*i +: 64]
                     + {63'd0, f_rbit(in_vd[8*i], in_vd1[8*i], in_vxrm)};
            end
         endcase
      end
   end

   // Stage R: capture the rounded beat; fields only load on a valid beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_vec   <= '0;
         r_addr  <= '0;
         r_be    <= '0;
         r_mask  <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_vec  <= w_rnd_vec;
            r_addr <= in_addr;
            r_be   <= in_be;
            r_mask <= in_mask;
         end
      end
   end

   assign w_full   = (r_count == CW'(DEPTH));
   assign w_push   = r_valid;
   assign w_pop    = out_valid & out_ready;
   // A full FIFO still accepts when the head leaves in the same cycle.
   assign w_accept = w_push & (~w_full | w_pop);

   // FIFO storage write; contents are don't-care until counted in.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem_vec[r_wptr]  <= r_vec;
         r_mem_addr[r_wptr] <= r_addr;
         r_mem_be[r_wptr]   <= r_be;
         r_mem_mask[r_wptr] <= r_mask;
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_accept)
            r_wptr <= r_wptr + PW'(1);
         if (w_pop)
            r_rptr <= r_rptr + PW'(1);
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_push & w_full & ~w_pop)
            r_overflow <= 1'b1;
      end
   end

   assign in_almost_full = (r_count >= CW'(DEPTH - 2));
   assign out_valid      = (r_count != '0);
   // Head fields are forced to zero while empty so reset shows clean outputs.
   assign out_vec        = out_valid ? r_mem_vec[r_rptr]  : '0;
   assign out_addr       = out_valid ? r_mem_addr[r_rptr] : '0;
   assign out_be         = out_valid ? r_mem_be[r_rptr]   : '0;
   assign out_mask       = out_valid ? r_mem_mask[r_rptr] : 1'b0;
   assign overflow       = r_overflow;

endmodule

// File: tb/tb_vfxp_round_wb.sv
// Self-checking bench for vfxp_round_wb: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_vfxp_round_wb;

   localparam int DW    = 64;
   localparam int BW    = 8;
   localparam int AW    = 32;
   localparam int DEPTH = 4;
   localparam bit EN64  = 1'b0;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [DW-1:0] in_vec;
   logic [AW-1:0] in_addr;
   logic [BW-1:0] in_be;
   logic          in_mask;
   logic          in_fxp;
   logic [BW-1:0] in_vd;
   logic [BW-1:0] in_vd1;
   logic [1:0]    in_sew;
   logic [1:0]    in_vxrm;
   logic          in_almost_full;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_vec;
   logic [AW-1:0] out_addr;
   logic [BW-1:0] out_be;
   logic          out_mask;
   logic          overflow;

   int checks;
   int failures;

   typedef struct {
      logic [63:0] vec;
      logic [31:0] addr;
      logic [7:0]  be;
      logic        mask;
   } beat_t;

   vfxp_round_wb #(
      .DATA_WIDTH(DW),
      .BE_WIDTH(BW),
      .ADDR_WIDTH(AW),
      .DEPTH(DEPTH),
      .ENABLE_64_BIT(EN64)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_vec(in_vec),
      .in_addr(in_addr),
      .in_be(in_be),
      .in_mask(in_mask),
      .in_fxp(in_fxp),
      .in_vd(in_vd),
      .in_vd1(in_vd1),
      .in_sew(in_sew),
      .in_vxrm(in_vxrm),
      .in_almost_full(in_almost_full),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_vec(out_vec),
      .out_addr(out_addr),
      .out_be(out_be),
      .out_mask(out_mask),
      .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference rounding: slice each element out arithmetically, add its
   // increment, wrap modulo 2^SEW and splice it back.
   function automatic logic [63:0] ref_round(input logic [63:0] v, input logic [7:0] vd,
                                             input logic [7:0] vd1, input logic [1:0] sew,
                                             input logic [1:0] vxrm, input logic fxp,
                                             input logic mask);
      logic [63:0] res;
      logic [63:0] m;
      logic [63:0] elem;
      int          ebytes;
      int          k;
      int          r;
      if (!fxp || mask || (sew == 2'd3 && !EN64)) return v;
      res    = v;
      ebytes = 1 << sew;
      m      = (ebytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * ebytes)) - 64'd1);
      for (int e = 0; e < 8 / ebytes; e++) begin
         k    = e * ebytes;
         elem = (v >> (8 * k)) & m;
         case (vxrm)
            2'd0:    r = vd1[k] ? 1 : 0;
            2'd1:    r = (vd1[k] && vd[k]) ? 1 : 0;
            2'd2:    r = 0;
            default: r = (!vd[k] && vd1[k]) ? 1 : 0;
         endcase
         elem = (elem + 64'(r)) & m;
         res  = (res & ~(m << (8 * k))) | (elem << (8 * k));
      end
      return res;
   endfunction

   task automatic idle_inputs();
      in_valid = 1'b0;
      in_vec   = '0;
      in_addr  = '0;
      in_be    = '0;
      in_mask  = 1'b0;
      in_fxp   = 1'b0;
      in_vd    = '0;
      in_vd1   = '0;
      in_sew   = '0;
      in_vxrm  = '0;
   endtask

   task automatic set_beat(input logic [63:0] v, input logic [31:0] a, input logic [7:0] be,
                           input logic m, input logic fxp, input logic [7:0] vd,
                           input logic [7:0] vd1, input logic [1:0] sew, input logic [1:0] vxrm);
      in_valid = 1'b1;
      in_vec   = v;
      in_addr  = a;
      in_be    = be;
      in_mask  = m;
      in_fxp   = fxp;
      in_vd    = vd;
      in_vd1   = vd1;
      in_sew   = sew;
      in_vxrm  = vxrm;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      out_ready = 1'b0;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      out_ready = 1'b0;
      idle_inputs();
      @(negedge clk);
      checks++;
      if ({out_valid, out_mask, overflow, in_almost_full} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags: got %b want 0000", {out_valid, out_mask, overflow, in_almost_full});
      end
      checks++;
      if ({out_vec, out_addr, out_be} !== '0) begin
         failures++;
         $display("FAIL reset_data: got vec=%h addr=%h be=%h want zeros", out_vec, out_addr, out_be);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_valid: got %b want 0", out_valid);
      end
   endtask

   task automatic test_rnu_wrap();
      do_reset();
      set_beat(64'h0000_0000_0000_00FF, 32'h100, 8'hFF, 1'b0, 1'b1, 8'h01, 8'h01, 2'd0, 2'd0);
      @(negedge clk);
      idle_inputs();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rnu_latency1: got out_valid=%b want 0", out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL rnu_latency2: got out_valid=%b want 1", out_valid);
      end
      checks++;
      if (out_vec !== 64'h0 || out_addr !== 32'h100 || out_be !== 8'hFF) begin
         failures++;
         $display("FAIL rnu_wrap: got vec=%h addr=%h be=%h want 0 100 ff", out_vec, out_addr, out_be);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rnu_pop: got out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_modes_sew16();
      logic [1:0]  modes [3];
      logic [63:0] exps  [3];
      modes[0] = 2'd1; exps[0] = 64'h0000_0000_0002_0004;
      modes[1] = 2'd3; exps[1] = 64'h0000_0000_0003_0003;
      modes[2] = 2'd2; exps[2] = 64'h0000_0000_0002_0003;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_beat(64'h0000_0000_0002_0003, 32'h180 + i, 8'h0F, 1'b0, 1'b1, 8'h01, 8'h05, 2'd1, modes[i]);
         @(negedge clk);
         idle_inputs();
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_vec !== exps[i]) begin
            failures++;
            $display("FAIL sew16_mode%0d: got valid=%b vec=%h want 1 %h", modes[i], out_valid, out_vec, exps[i]);
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_mask();
      do_reset();
      set_beat(64'h0123_4567_89AB_CDEF, 32'h1C0, 8'hA5, 1'b1, 1'b1, 8'h00, 8'hFF, 2'd0, 2'd0);
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_vec !== 64'h0123_4567_89AB_CDEF || out_mask !== 1'b1 || out_be !== 8'hA5) begin
         failures++;
         $display("FAIL mask_passthru: got valid=%b vec=%h mask=%b be=%h want 1 0123456789abcdef 1 a5",
                  out_valid, out_vec, out_mask, out_be);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_overflow();
      int cnt;
      do_reset();
      for (int j = 0; j < 7; j++) begin
         if (j < 5)
            set_beat(64'hA0 + 64'(j), 32'h200 + 32'(j), 8'h01 << j, 1'b0, 1'b0, '0, '0, 2'd0, 2'd0);
         else
            idle_inputs();
         @(negedge clk);
         cnt = (j < 4) ? j : 4;
         checks++;
         if (in_almost_full !== (cnt >= DEPTH - 2) || overflow !== (j >= 5) || out_valid !== (j >= 1)) begin
            failures++;
            $display("FAIL ovf_fill_%0d: got af=%b ovf=%b valid=%b want %b %b %b", j,
                     in_almost_full, overflow, out_valid, cnt >= DEPTH - 2, j >= 5, j >= 1);
         end
         if (j >= 1) begin
            checks++;
            if (out_addr !== 32'h200 || out_vec !== 64'hA0) begin
               failures++;
               $display("FAIL ovf_hold_%0d: got addr=%h vec=%h want 200 a0", j, out_addr, out_vec);
            end
         end
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_addr !== 32'h200 + 32'(i) || out_be !== (8'h01 << i) || out_vec !== 64'hA0 + 64'(i)) begin
            failures++;
            $display("FAIL ovf_drain_%0d: got valid=%b addr=%h be=%h vec=%h want 1 %h %h %h", i,
                     out_valid, out_addr, out_be, out_vec, 32'h200 + 32'(i), 8'h01 << i, 64'hA0 + 64'(i));
         end
         @(negedge clk);
      end
      checks++;
      if (out_valid !== 1'b0 || overflow !== 1'b1) begin
         failures++;
         $display("FAIL ovf_after_drain: got valid=%b ovf=%b want 0 1", out_valid, overflow);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_full_push_pop();
      do_reset();
      for (int j = 0; j < 5; j++) begin
         set_beat(64'hB0 + 64'(j), 32'h300 + 32'(j), 8'hF0, 1'b0, 1'b0, '0, '0, 2'd0, 2'd0);
         @(negedge clk);
      end
      idle_inputs();
      checks++;
      if (in_almost_full !== 1'b1 || out_addr !== 32'h300) begin
         failures++;
         $display("FAIL full_state: got af=%b addr=%h want 1 300", in_almost_full, out_addr);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_addr !== 32'h300 + 32'(i) || out_vec !== 64'hB0 + 64'(i)) begin
            failures++;
            $display("FAIL full_order_%0d: got valid=%b addr=%h vec=%h want 1 %h %h", i,
                     out_valid, out_addr, out_vec, 32'h300 + 32'(i), 64'hB0 + 64'(i));
         end
         @(negedge clk);
      end
      checks++;
      if (out_valid !== 1'b0 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL full_no_drop: got valid=%b ovf=%b want 0 0", out_valid, overflow);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int j = 0; j < 3; j++) begin
         set_beat(64'hC0 + 64'(j), 32'h400 + 32'(j), 8'h0F, 1'b0, 1'b0, '0, '0, 2'd0, 2'd0);
         @(negedge clk);
      end
      idle_inputs();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_almost_full !== 1'b1) begin
         failures++;
         $display("FAIL arst_prefill: got valid=%b af=%b want 1 1", out_valid, in_almost_full);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_vec !== '0 || in_almost_full !== 1'b0) begin
         failures++;
         $display("FAIL arst_immediate: got valid=%b vec=%h af=%b want 0 0 0", out_valid, out_vec, in_almost_full);
      end
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b0;
      set_beat(64'hD5, 32'h480, 8'h3C, 1'b0, 1'b0, '0, '0, 2'd0, 2'd0);
      @(negedge clk);
      idle_inputs();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL arst_lat1: got valid=%b want 0", out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_addr !== 32'h480 || out_vec !== 64'hD5) begin
         failures++;
         $display("FAIL arst_lat2: got valid=%b addr=%h vec=%h want 1 480 d5", out_valid, out_addr, out_vec);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      beat_t       mq[$];
      beat_t       stage;
      beat_t       nb;
      logic        st_valid;
      logic        ovf;
      logic        rdy;
      logic        pop;
      logic [63:0] v;
      logic [7:0]  vd;
      logic [7:0]  vd1;
      logic [1:0]  sew;
      logic [1:0]  vxrm;
      logic        fxp;
      logic        msk;
      do_reset();
      st_valid = 1'b0;
      ovf      = 1'b0;
      stage    = '{vec: '0, addr: '0, be: '0, mask: 1'b0};
      for (int cyc = 0; cyc < 600; cyc++) begin
         checks++;
         if (out_valid !== (mq.size() != 0)) begin
            failures++;
            $display("FAIL rnd_valid c%0d: got %b want %b", cyc, out_valid, mq.size() != 0);
         end
         if (mq.size() != 0) begin
            checks++;
            if (out_vec !== mq[0].vec || out_addr !== mq[0].addr || out_be !== mq[0].be || out_mask !== mq[0].mask) begin
               failures++;
               $display("FAIL rnd_head c%0d: got %h/%h/%h/%b want %h/%h/%h/%b", cyc, out_vec, out_addr,
                        out_be, out_mask, mq[0].vec, mq[0].addr, mq[0].be, mq[0].mask);
            end
         end
         checks++;
         if (in_almost_full !== (mq.size() >= DEPTH - 2) || overflow !== ovf) begin
            failures++;
            $display("FAIL rnd_flags c%0d: got af=%b ovf=%b want %b %b", cyc, in_almost_full, overflow,
                     mq.size() >= DEPTH - 2, ovf);
         end
         rdy       = ($urandom_range(0, 3) != 0);
         out_ready = rdy;
         pop       = rdy && (mq.size() != 0);
         if (pop) void'(mq.pop_front());
         if (st_valid) begin
            if (mq.size() < DEPTH) mq.push_back(stage);
            else ovf = 1'b1;
         end
         if ($urandom_range(0, 1) == 1) begin
            v    = {$urandom(), $urandom()};
            vd   = 8'($urandom());
            vd1  = 8'($urandom());
            sew  = 2'($urandom());
            vxrm = 2'($urandom());
            fxp  = ($urandom_range(0, 7) != 0);
            msk  = ($urandom_range(0, 7) == 0);
            nb.vec  = ref_round(v, vd, vd1, sew, vxrm, fxp, msk);
            nb.addr = $urandom();
            nb.be   = 8'($urandom());
            nb.mask = msk;
            set_beat(v, nb.addr, nb.be, msk, fxp, vd, vd1, sew, vxrm);
            stage    = nb;
            st_valid = 1'b1;
         end else begin
            idle_inputs();
            in_vec   = {$urandom(), $urandom()};
            st_valid = 1'b0;
         end
         @(negedge clk);
      end
      idle_inputs();
      out_ready = 1'b0;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      out_ready = 1'b0;
      idle_inputs();
      test_reset();
      test_rnu_wrap();
      test_modes_sew16();
      test_mask();
      test_overflow();
      test_full_push_pop();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

endmodule
